// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one partial-product step per clock, WIDTH steps per operation.
// Define SIGNED_MODE_EN to honour signed_mode (sign-magnitude wrap around the unsigned core).
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               process_start,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               signed_mode,
    output logic [2*WIDTH-1:0] product,
    output logic               process_done,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign w_accept = process_start && (r_state != CALC);
    assign w_last   = (r_state == CALC) && (r_cnt == LAST);

    // Upper half plus carry receives the addend; the whole accumulator then shifts right.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

`ifdef SIGNED_MODE_EN
    logic r_neg;
    logic w_neg_in;

    // Unary minus of the most negative value yields 2^(WIDTH-1) as an unsigned magnitude.
    assign w_mag_a  = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign w_mag_b  = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign w_neg_in = signed_mode && (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
    assign w_result = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_neg_in;
        end
    end
`else
    logic w_unused_sign;

    assign w_unused_sign = signed_mode;
    assign w_mag_a       = multiplier;
    assign w_mag_b       = multiplicand;
    assign w_result      = w_acc_next;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (process_start) w_next = CALC;
            CALC:    if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = process_start ? CALC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_mplier  <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_mplier <= w_mag_a;
                r_mcand  <= w_mag_b;
                r_cnt    <= '0;
                r_acc    <= '0;
            end else if (r_state == CALC) begin
                r_acc    <= w_acc_next;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_product <= w_result;
                end
            end
        end
    end

    assign product      = r_product;
    assign process_done = r_done;
    assign busy         = (r_state == CALC);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: an 8-bit instance for most scenarios plus a 4-bit one.
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         start;
    logic [7:0]   mplier;
    logic [7:0]   mcand;
    logic         smode;
    logic [15:0]  product;
    logic         done;
    logic         busy;

    logic         start4;
    logic [3:0]   a4;
    logic [3:0]   b4;
    logic [7:0]   product4;
    logic         done4;
    logic         busy4;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    shift_add_multiplier #(.WIDTH(W)) u_dut (
        .CLK(CLK), .RESET(RESET), .process_start(start),
        .multiplier(mplier), .multiplicand(mcand), .signed_mode(smode),
        .product(product), .process_done(done), .busy(busy)
    );

    shift_add_multiplier #(.WIDTH(4)) u_dut4 (
        .CLK(CLK), .RESET(RESET), .process_start(start4),
        .multiplier(a4), .multiplicand(b4), .signed_mode(1'b0),
        .product(product4), .process_done(done4), .busy(busy4)
    );

    // Called at a negedge just after the accepting edge; n = negedges until done is seen.
    task automatic wait_done(output int n, output int bcnt);
        n = 0;
        bcnt = 0;
        while (!done && n < 20) begin
            if (busy) bcnt++;
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] exp, input string name);
        int n, bcnt;
        @(negedge CLK);
        RESET = 1'b0;
        mplier = a; mcand = b; smode = s; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        mplier = ~a; mcand = ~b; smode = ~s;
        wait_done(n, bcnt);
        checks++;
        if (n !== W) begin
            failures++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, n, W);
        end
        checks++;
        if (bcnt !== W) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, bcnt, W);
        end
        checks++;
        if (product !== exp) begin
            failures++;
            $display("FAIL %s product: got %h, expected %h", name, product, exp);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b, expected 0 0", name, done, busy);
        end
        checks++;
        if (product !== exp) begin
            failures++;
            $display("FAIL %s hold: got %h, expected %h", name, product, exp);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b0; start4 = 1'b0;
        mplier = '0; mcand = '0; smode = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if (product !== 16'h0000 || product4 !== 8'h00) begin
            failures++;
            $display("FAIL reset_product: got %h/%h, expected 0000/00", product, product4);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_unsigned();
        // First call releases RESET and starts on the same edge.
        run_op(8'h04, 8'h09, 1'b0, 16'h0024, "u_4x9");
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ffxff");
        run_op(8'h00, 8'hA5, 1'b0, 16'h0000, "u_0xa5");
        run_op(8'hA5, 8'h01, 1'b0, 16'h00A5, "u_a5x1");
    endtask

    task automatic test_signed();
`ifdef SIGNED_MODE_EN
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_x_min");
        run_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
        run_op(8'h7F, 8'h81, 1'b1, 16'hC0FF, "s_127xm127");
        run_op(8'hFD, 8'h05, 1'b0, 16'h04F1, "s_off_fdx05");
`else
        run_op(8'hFD, 8'h05, 1'b1, 16'h04F1, "nosign_fdx05");
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, "nosign_80x80");
        run_op(8'h7F, 8'h81, 1'b1, 16'h3FFF, "nosign_7fx81");
`endif
    endtask

    task automatic test_back_to_back();
        int n, bcnt;
        @(negedge CLK);
        mplier = 8'h0C; mcand = 8'h0B; smode = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        mplier = 8'hFF; mcand = 8'hFF; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done(n, bcnt);
        checks++;
        if (n !== 5 || product !== 16'h0084) begin
            failures++;
            $display("FAIL b2b_ignore: n=%0d product=%h, expected 5 0084", n, product);
        end
        mplier = 8'h11; mcand = 8'h0F; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || product !== 16'h0084) begin
            failures++;
            $display("FAIL b2b_gap: busy=%b done=%b product=%h, expected 1 0 0084", busy, done, product);
        end
        wait_done(n, bcnt);
        checks++;
        if (n !== W || product !== 16'h00FF) begin
            failures++;
            $display("FAIL b2b_second: n=%0d product=%h, expected %0d 00ff", n, product, W);
        end
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        @(negedge CLK);
        mplier = 8'h33; mcand = 8'h07; smode = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: product=%h busy=%b done=%b, expected 0000 0 0", product, busy, done);
        end
        seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midreset_pulse: got %0d pulses, expected 0", seen);
        end
        run_op(8'h33, 8'h07, 1'b0, 16'h0165, "after_reset");
    endtask

    task automatic test_width4();
        int n, bcnt;
        @(negedge CLK);
        a4 = 4'd4; b4 = 4'd9; start4 = 1'b1;
        @(negedge CLK);
        start4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
        n = 0; bcnt = 0;
        while (!done4 && n < 20) begin
            if (busy4) bcnt++;
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n !== 4 || bcnt !== 4) begin
            failures++;
            $display("FAIL w4_timing: latency=%0d busy=%0d, expected 4 4", n, bcnt);
        end
        checks++;
        if (product4 !== 8'h24) begin
            failures++;
            $display("FAIL w4_product: got %h, expected 24", product4);
        end
        @(negedge CLK);
        checks++;
        if (done4 !== 1'b0) begin
            failures++;
            $display("FAIL w4_single_pulse: done=%b, expected 0", done4);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_mid_calc();
        test_width4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
